// File: rtl/lab2_proc_pkg.sv
// rtl/lab2_proc_pkg.sv - shared types and helpers for the lab2 processor
package lab2_proc_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Counters must hold the full range 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lab2_proc_fetch_queue.sv
// rtl/lab2_proc_fetch_queue.sv - circular FIFO with registered head and synchronous flush
module lab2_proc_fetch_queue
  import lab2_proc_pkg::*;
#(
  parameter int p_width = 32,
  parameter int p_depth = 2,
  localparam int c_cnt_w = cnt_width(p_depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               enq_val,
  input  logic [p_width-1:0] enq_data,
  input  logic               deq_en,
  output logic [p_width-1:0] head_data,
  output logic [c_cnt_w-1:0] count
);

  localparam int c_ptr_w = $clog2(p_depth);

  logic [p_width-1:0] mem [p_depth];
  logic [c_ptr_w-1:0] head;
  logic [c_ptr_w-1:0] tail;
  logic [c_ptr_w-1:0] head_nxt;
  logic [p_width-1:0] head_q;

  assign head_nxt  = head + c_ptr_w'(1);
  assign head_data = head_q;

  always_ff @(posedge clk) begin
    if (!flush && enq_val)
      mem[tail] <= enq_data;
  end

  // head_q shadows mem[head] so the output comes straight off a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      head_q <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_val)
        tail <= tail + c_ptr_w'(1);
      if (deq_en)
        head <= head_nxt;
      count <= count + c_cnt_w'(enq_val) - c_cnt_w'(deq_en);
      if (deq_en) begin
        if (count > c_cnt_w'(1))
          head_q <= mem[head_nxt];
        else if (enq_val)
          head_q <= enq_data;
      end else if (count == '0 && enq_val) begin
        head_q <= enq_data;
      end
    end
  end

endmodule

// File: rtl/lab2_proc_fetch_buffer.sv
// rtl/lab2_proc_fetch_buffer.sv - F/D decoupling buffer pairing imem responses with request PCs
module lab2_proc_fetch_buffer
  import lab2_proc_pkg::*;
#(
  parameter int p_num_entries = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_fire,
  input  logic [31:0] req_pc,
  output logic        req_rdy,
  input  logic        resp_val,
  input  logic [31:0] resp_inst,
  input  logic        squash,
  output logic        deq_val,
  input  logic        deq_rdy,
  output logic [31:0] deq_pc,
  output logic [31:0] deq_inst
);

  localparam int c_cnt_w = cnt_width(p_num_entries);
  localparam logic [c_cnt_w:0] c_limit = (c_cnt_w + 1)'(p_num_entries);

  logic [c_cnt_w-1:0] count;
  logic [c_cnt_w-1:0] inflight;
  logic [c_cnt_w-1:0] drop;
  logic [31:0]        pc_head;
  fetch_entry_t       enq_entry;
  fetch_entry_t       head_entry;
  logic               resp_ok;
  logic               inst_enq;
  logic               deq_fire;

  // A response with nothing outstanding is ignored so no counter underflows
  assign resp_ok  = resp_val && (inflight != '0);
  assign inst_enq = resp_ok && (drop == '0) && !squash;

  assign enq_entry.pc   = pc_head;
  assign enq_entry.inst = resp_inst;

  assign req_rdy  = ({1'b0, count} + {1'b0, inflight}) < c_limit;
  assign deq_val  = (count != '0) && !squash;
  assign deq_fire = deq_val && deq_rdy;
  assign deq_pc   = head_entry.pc;
  assign deq_inst = head_entry.inst;

  // pc FIFO occupancy is exactly the number of outstanding requests
  lab2_proc_fetch_queue #(
    .p_width (32),
    .p_depth (p_num_entries)
  ) pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .enq_val   (req_fire),
    .enq_data  (req_pc),
    .deq_en    (resp_ok),
    .head_data (pc_head),
    .count     (inflight)
  );

  lab2_proc_fetch_queue #(
    .p_width (64),
    .p_depth (p_num_entries)
  ) inst_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (squash),
    .enq_val   (inst_enq),
    .enq_data  (enq_entry),
    .deq_en    (deq_fire),
    .head_data (head_entry),
    .count     (count)
  );

  // Every request outstanding at squash time is stale; a same-cycle req_fire is not
  always_ff @(posedge clk) begin
    if (reset)
      drop <= '0;
    else if (squash)
      drop <= inflight - c_cnt_w'(resp_ok);
    else if (resp_ok && drop != '0)
      drop <= drop - c_cnt_w'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(req_fire && !req_rdy))
        else $warning("protocol violation: req_fire without credit");
      assert (!(resp_val && inflight == '0))
        else $warning("protocol violation: resp_val with no request in flight");
    end
  end

endmodule

// File: tb/tb_lab2_proc_fetch_buffer.sv
// tb/tb_lab2_proc_fetch_buffer.sv - directed self-checking bench for lab2_proc_fetch_buffer
module tb_lab2_proc_fetch_buffer;

  logic        clk;
  logic        reset;

  logic        req_fire, resp_val, squash, deq_rdy, req_rdy, deq_val;
  logic [31:0] req_pc, resp_inst, deq_pc, deq_inst;

  logic        s_req_fire, s_resp_val, s_squash, s_deq_rdy, s_req_rdy, s_deq_val;
  logic [31:0] s_req_pc, s_resp_inst, s_deq_pc, s_deq_inst;

  int n_checks = 0;
  int n_fail   = 0;

  lab2_proc_fetch_buffer #(.p_num_entries(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_fire  (req_fire),
    .req_pc    (req_pc),
    .req_rdy   (req_rdy),
    .resp_val  (resp_val),
    .resp_inst (resp_inst),
    .squash    (squash),
    .deq_val   (deq_val),
    .deq_rdy   (deq_rdy),
    .deq_pc    (deq_pc),
    .deq_inst  (deq_inst)
  );

  lab2_proc_fetch_buffer #(.p_num_entries(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .req_fire  (s_req_fire),
    .req_pc    (s_req_pc),
    .req_rdy   (s_req_rdy),
    .resp_val  (s_resp_val),
    .resp_inst (s_resp_inst),
    .squash    (s_squash),
    .deq_val   (s_deq_val),
    .deq_rdy   (s_deq_rdy),
    .deq_pc    (s_deq_pc),
    .deq_inst  (s_deq_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    req_fire = 0; req_pc = '0; resp_val = 0; resp_inst = '0; squash = 0;
    s_req_fire = 0; s_req_pc = '0; s_resp_val = 0; s_resp_inst = '0; s_squash = 0;
  endtask

  initial begin
    idle();
    deq_rdy = 1; s_deq_rdy = 1;
    reset = 1;
    cyc(); cyc();
    reset = 0;
    #1;
    chk("rst_deq_val", deq_val, 0);
    chk("rst_deq_pc", deq_pc, 0);
    chk("rst_deq_inst", deq_inst, 0);
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_count", dut.count, 0);
    chk("rst_inflight", dut.inflight, 0);
    chk("rst_drop", dut.drop, 0);

    // streaming on the depth-4 instance
    s_req_fire = 1; s_req_pc = 32'h200; #1;
    chk("st0_rdy", s_req_rdy, 1);
    cyc();
    s_req_pc = 32'h204; s_resp_val = 1; s_resp_inst = 32'h1111_1111; #1;
    chk("st1_rdy", s_req_rdy, 1);
    chk("st1_val", s_deq_val, 0);
    cyc();
    s_req_pc = 32'h208; s_resp_inst = 32'h2222_2222; #1;
    chk("st2_rdy", s_req_rdy, 1);
    chk("st2_val", s_deq_val, 1);
    chk("st2_pc", s_deq_pc, 32'h200);
    chk("st2_inst", s_deq_inst, 32'h1111_1111);
    cyc();
    s_req_fire = 0; s_resp_inst = 32'h3333_3333; #1;
    chk("st3_rdy", s_req_rdy, 1);
    chk("st3_pc", s_deq_pc, 32'h204);
    chk("st3_inst", s_deq_inst, 32'h2222_2222);
    cyc();
    idle(); #1;
    chk("st4_val", s_deq_val, 1);
    chk("st4_pc", s_deq_pc, 32'h208);
    chk("st4_inst", s_deq_inst, 32'h3333_3333);
    cyc(); #1;
    chk("st5_val", s_deq_val, 0);

    // backpressure on the depth-2 instance
    deq_rdy = 0;
    req_fire = 1; req_pc = 32'h100; #1;
    chk("bp0_rdy", req_rdy, 1);
    cyc();
    req_pc = 32'h104; resp_val = 1; resp_inst = 32'h0000_00a0; #1;
    chk("bp1_rdy", req_rdy, 1);
    cyc();
    req_fire = 0; resp_inst = 32'h0000_00a1; #1;
    chk("bp2_rdy", req_rdy, 0);
    cyc();
    idle(); deq_rdy = 1; #1;
    chk("bp3_rdy", req_rdy, 0);
    chk("bp3_pc", deq_pc, 32'h100);
    chk("bp3_inst", deq_inst, 32'h0000_00a0);
    cyc();
    deq_rdy = 0; #1;
    chk("bp4_rdy", req_rdy, 1);
    chk("bp4_pc", deq_pc, 32'h104);
    chk("bp4_inst", deq_inst, 32'h0000_00a1);
    deq_rdy = 1;
    cyc(); #1;
    chk("bp5_val", deq_val, 0);

    // squash with two in flight
    req_fire = 1; req_pc = 32'h500;
    cyc();
    req_pc = 32'h504;
    cyc();
    req_fire = 0; squash = 1; #1;
    chk("sq0_val", deq_val, 0);
    cyc();
    squash = 0; #1;
    chk("sq1_drop", dut.drop, 2);
    chk("sq1_inflight", dut.inflight, 2);
    chk("sq1_rdy", req_rdy, 0);
    resp_val = 1; resp_inst = 32'hbad0_0000;
    cyc();
    resp_inst = 32'hbad1_0000; #1;
    chk("sq2_drop", dut.drop, 1);
    chk("sq2_val", deq_val, 0);
    cyc();
    resp_val = 0; #1;
    chk("sq3_drop", dut.drop, 0);
    chk("sq3_val", deq_val, 0);
    req_fire = 1; req_pc = 32'h300;
    cyc();
    req_fire = 0; resp_val = 1; resp_inst = 32'h0000_3000;
    cyc();
    idle(); #1;
    chk("sq4_val", deq_val, 1);
    chk("sq4_pc", deq_pc, 32'h300);
    chk("sq4_inst", deq_inst, 32'h0000_3000);
    cyc(); #1;
    chk("sq5_val", deq_val, 0);

    // squash with coincident response and request, depth-4 instance
    s_deq_rdy = 0;
    s_req_fire = 1; s_req_pc = 32'h600;
    cyc();
    s_req_pc = 32'h604; s_resp_val = 1; s_resp_inst = 32'h0000_6000;
    cyc();
    s_req_pc = 32'h608; s_resp_val = 0;
    cyc();
    s_squash = 1; s_resp_val = 1; s_resp_inst = 32'hdead_0000; s_req_pc = 32'h400; #1;
    chk("cs0_val_forced", s_deq_val, 0);
    chk("cs0_rdy", s_req_rdy, 1);
    cyc();
    idle(); #1;
    chk("cs1_drop", dut4.drop, 1);
    chk("cs1_inflight", dut4.inflight, 2);
    chk("cs1_count", dut4.count, 0);
    s_resp_val = 1; s_resp_inst = 32'hbeef_0000;
    cyc();
    s_resp_inst = 32'h0000_4000; #1;
    chk("cs2_drop", dut4.drop, 0);
    chk("cs2_val", s_deq_val, 0);
    cyc();
    idle(); #1;
    chk("cs3_val", s_deq_val, 1);
    chk("cs3_pc", s_deq_pc, 32'h400);
    chk("cs3_inst", s_deq_inst, 32'h0000_4000);
    s_deq_rdy = 1;
    cyc(); #1;
    chk("cs4_val", s_deq_val, 0);
    chk("cs4_inflight", dut4.inflight, 0);

    // reset with two buffered and one in flight
    s_deq_rdy = 0;
    s_req_fire = 1; s_req_pc = 32'h700;
    cyc();
    s_req_pc = 32'h704; s_resp_val = 1; s_resp_inst = 32'h0000_7000;
    cyc();
    s_req_pc = 32'h708; s_resp_inst = 32'h0000_7004;
    cyc();
    idle(); #1;
    chk("rm0_count", dut4.count, 2);
    chk("rm0_inflight", dut4.inflight, 1);
    reset = 1;
    cyc();
    reset = 0; #1;
    chk("rm1_val", s_deq_val, 0);
    chk("rm1_rdy", s_req_rdy, 1);
    chk("rm1_count", dut4.count, 0);
    chk("rm1_inflight", dut4.inflight, 0);
    chk("rm1_drop", dut4.drop, 0);
    chk("rm1_pc", s_deq_pc, 0);

    // stray response after reset is ignored
    s_resp_val = 1; s_resp_inst = 32'h0000_7008;
    cyc();
    idle(); #1;
    chk("pv_count", dut4.count, 0);
    chk("pv_val", s_deq_val, 0);
    chk("pv_inflight", dut4.inflight, 0);
    chk("pv_rdy", s_req_rdy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
